// File: rtl/matmul_apb_master.sv
// Single-command APB4 master in front of the matmul accelerator's APB slave port.
// Optional ACCESS-phase watchdog enabled by defining MATMUL_APB_TIMEOUT_EN.
module matmul_apb_master #(
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DIM        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BUS_WIDTH-1:0]  req_wdata_i,
    input  logic [MAX_DIM-1:0]    req_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;

    localparam int BYTES = BUS_WIDTH / 8;

    logic misaligned;
    logic timeout;
    assign misaligned = (req_addr_i % ADDR_WIDTH'(BYTES)) != '0;

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;

    // cnt holds the number of ACCESS cycles already completed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               cnt <= '0;
        else if (state == SETUP)   cnt <= '0;
        else if (state == ACCESS)  cnt <= cnt + 1'b1;
    end
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    req_ready_o <= 1'b0;
                    busy_o      <= 1'b1;
                    if (misaligned) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end else begin
                        state    <= SETUP;
                        psel_o   <= 1'b1;
                        pwrite_o <= req_write_i;
                        paddr_o  <= req_addr_i;
                        // APB4: reads carry no write data and no strobes
                        pwdata_o <= req_write_i ? req_wdata_i : '0;
                        pstrb_o  <= req_write_i ? req_strb_i  : '0;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_o <= 1'b1;
                end
                ACCESS: if (pready_i || timeout) begin
                    state       <= RESP;
                    psel_o      <= 1'b0;
                    penable_o   <= 1'b0;
                    pwrite_o    <= 1'b0;
                    paddr_o     <= '0;
                    pwdata_o    <= '0;
                    pstrb_o     <= '0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= pready_i ? pslverr_i : 1'b1;
                    rsp_rdata_o <= (pready_i && !pwrite_o && !pslverr_i) ? prdata_i : '0;
                end
                RESP: if (rsp_ready_i) begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
